// File: rtl/uart_pkg.sv
// Shared UART types and line levels for the transmit/receive pair.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } xmt_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int DEF_BIT_CYCLES = 8;

endpackage

// File: rtl/uart_xmt_datapath.sv
// Transmit datapath: shift register, sample/bit counters and the stored parity bit.
// Driven entirely by strobes from the uart_xmt controller.
module xmt_datapath
   import uart_pkg::*;
#(
   parameter int WORDSIZE   = 8,
   parameter int BIT_CYCLES = DEF_BIT_CYCLES
`ifdef UART_XMT_PARITY_EN
   , parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                              sclk,
   input  logic                              reset,
   input  logic [WORDSIZE-1:0]               data_in,
   input  logic                              load,
   input  logic                              clr,
   input  logic                              shift,
   input  logic                              inc_sample,
   input  logic                              inc_bit,
   output logic                              cur_bit,
   output logic                              nxt_bit,
   output logic [$clog2(BIT_CYCLES)-1:0]     sample_cnt,
   output logic [$clog2(WORDSIZE+1)-1:0]     bit_cnt
`ifdef UART_XMT_PARITY_EN
   , output logic                            parity
`endif
);

   localparam int SCW = $clog2(BIT_CYCLES);
   localparam int BCW = $clog2(WORDSIZE+1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(BIT_CYCLES-1);

   logic [WORDSIZE-1:0] shreg;

   assign cur_bit = shreg[0];
   assign nxt_bit = shreg[1];

   always_ff @(posedge sclk) begin
      if (!reset) begin
         shreg      <= '0;
         sample_cnt <= '0;
         bit_cnt    <= '0;
      end else begin
         if (load)
            shreg <= data_in;
         else if (shift)
            shreg <= {1'b0, shreg[WORDSIZE-1:1]};

         if (clr)
            sample_cnt <= '0;
         else if (inc_sample)
            sample_cnt <= (sample_cnt == SC_LAST) ? '0 : sample_cnt + SCW'(1);

         if (clr)
            bit_cnt <= '0;
         else if (inc_bit)
            bit_cnt <= bit_cnt + BCW'(1);
      end
   end

`ifdef UART_XMT_PARITY_EN
   always_ff @(posedge sclk) begin
      if (!reset)
         parity <= 1'b0;
      else if (load)
         parity <= (^data_in) ^ PARITY_ODD;
   end
`endif

endmodule

// File: rtl/uart_xmt.sv
// UART transmitter: start bit, WORDSIZE data bits LSB first, stop bit, BIT_CYCLES clocks each.
// Define UART_XMT_PARITY_EN to insert a parity bit (PARITY_ODD selects odd) before the stop bit.
module uart_xmt
   import uart_pkg::*;
#(
   parameter int WORDSIZE   = 8,
   parameter int BIT_CYCLES = DEF_BIT_CYCLES
`ifdef UART_XMT_PARITY_EN
   , parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                sclk,
   input  logic                reset,
   input  logic [WORDSIZE-1:0] data_in,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                serial_out,
   output logic                tx_busy,
   output logic                tx_done
);

   localparam int SCW = $clog2(BIT_CYCLES);
   localparam int BCW = $clog2(WORDSIZE+1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(BIT_CYCLES-1);
   localparam logic [SCW-1:0] SC_PRE  = SCW'(BIT_CYCLES-2);
   localparam logic [BCW-1:0] BC_LAST = BCW'(WORDSIZE-1);

   xmt_state_t     state, state_nxt;
   logic [SCW-1:0] sample_cnt;
   logic [BCW-1:0] bit_cnt;
   logic           cur_bit, nxt_bit;
   logic           load, clr, shift, inc_sample, inc_bit;
   logic           accept, sample_last, line_nxt;
`ifdef UART_XMT_PARITY_EN
   logic           parity;
`endif

   xmt_datapath #(
      .WORDSIZE   (WORDSIZE),
      .BIT_CYCLES (BIT_CYCLES)
`ifdef UART_XMT_PARITY_EN
      , .PARITY_ODD (PARITY_ODD)
`endif
   ) u_dp (
      .sclk       (sclk),
      .reset      (reset),
      .data_in    (data_in),
      .load       (load),
      .clr        (clr),
      .shift      (shift),
      .inc_sample (inc_sample),
      .inc_bit    (inc_bit),
      .cur_bit    (cur_bit),
      .nxt_bit    (nxt_bit),
      .sample_cnt (sample_cnt),
      .bit_cnt    (bit_cnt)
`ifdef UART_XMT_PARITY_EN
      , .parity   (parity)
`endif
   );

   assign sample_last = (sample_cnt == SC_LAST);
   assign tx_ready    = (state == IDLE) || (state == STOP && sample_last);
   assign tx_busy     = (state != IDLE);
   assign accept      = tx_valid && tx_ready;

   // line_nxt is the level the line takes after this edge, so serial_out tracks state exactly
   always_comb begin
      state_nxt  = state;
      line_nxt   = LINE_IDLE;
      load       = 1'b0;
      clr        = 1'b0;
      shift      = 1'b0;
      inc_sample = 1'b0;
      inc_bit    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               load      = 1'b1;
               clr       = 1'b1;
               state_nxt = START;
               line_nxt  = START_BIT;
            end
         end
         START: begin
            inc_sample = 1'b1;
            line_nxt   = START_BIT;
            if (sample_last) begin
               state_nxt = DATA;
               line_nxt  = cur_bit;
            end
         end
         DATA: begin
            inc_sample = 1'b1;
            line_nxt   = cur_bit;
            if (sample_last) begin
               shift   = 1'b1;
               inc_bit = 1'b1;
               if (bit_cnt == BC_LAST) begin
`ifdef UART_XMT_PARITY_EN
                  state_nxt = PARITY;
                  line_nxt  = parity;
`else
                  state_nxt = STOP;
                  line_nxt  = STOP_BIT;
`endif
               end else begin
                  line_nxt = nxt_bit;
               end
            end
         end
`ifdef UART_XMT_PARITY_EN
         PARITY: begin
            inc_sample = 1'b1;
            line_nxt   = parity;
            if (sample_last) begin
               state_nxt = STOP;
               line_nxt  = STOP_BIT;
            end
         end
`endif
         STOP: begin
            inc_sample = 1'b1;
            line_nxt   = STOP_BIT;
            if (sample_last) begin
               if (accept) begin
                  load      = 1'b1;
                  clr       = 1'b1;
                  state_nxt = START;
                  line_nxt  = START_BIT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            line_nxt  = LINE_IDLE;
         end
      endcase
   end

   always_ff @(posedge sclk) begin
      if (!reset) begin
         state      <= IDLE;
         serial_out <= LINE_IDLE;
         tx_done    <= 1'b0;
      end else begin
         state      <= state_nxt;
         serial_out <= line_nxt;
         tx_done    <= (state == STOP) && (sample_cnt == SC_PRE);
      end
   end

endmodule
